tdc_therm_decoder: RTL and testbench

- Downstream consumer of the TDC delay-chain flip-flop outputs.
- Registers the N-bit captured chain word and normalises its polarity, since alternate phase_reverse cycles invert the word.
- Optionally bubble-corrects the word, then encodes it to a binary fine code with offset removal.
- Contains a small calibration FSM that measures the zero-input offset by averaging 2^CAL_LOG2 raw codes; output feeds the ADC/TDC combiner.

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_therm_decoder_if.sv | 25 ++
 rtl/therm_first_zero_enc.sv | 19 +
 rtl/tdc_therm_decoder.sv | 131 +++++++++++++
 tb/tb_tdc_therm_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC thermometer decoder.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    LOAD
  } tdc_cal_state_t;

  localparam int DEF_N_CHAIN  = 64;
  localparam int DEF_N_OUT    = 7;
  localparam int DEF_CAL_LOG2 = 4;

  // Accumulator must hold 2^cal_log2 samples of up to N_CHAIN each.
  function automatic int acc_width(input int n_out, input int cal_log2);
    return n_out + cal_log2;
  endfunction

endpackage

// File: rtl/tdc_therm_decoder_if.sv
// Bus between the delay-chain capture logic and the thermometer decoder.
interface tdc_therm_decoder_if #(
  parameter int N_CHAIN = 64,
  parameter int N_OUT   = 7
);
  logic [N_CHAIN-1:0] therm_in;
  logic               in_valid;
  logic               cal_start;
  logic [N_OUT-1:0]   out_code;
  logic               out_valid;
  logic               out_ovf;
  logic               cal_busy;
  logic               cal_done;
  logic [N_OUT-1:0]   cal_offset;

  modport master (
    output therm_in, in_valid, cal_start,
    input  out_code, out_valid, out_ovf, cal_busy, cal_done, cal_offset
  );

  modport slave (
    input  therm_in, in_valid, cal_start,
    output out_code, out_valid, out_ovf, cal_busy, cal_done, cal_offset
  );
endinterface

// File: rtl/therm_first_zero_enc.sv
// Priority encoder: index of the lowest zero bit; all-ones yields N_CHAIN with ovf set.
module therm_first_zero_enc #(
  parameter int N_CHAIN = 64,
  parameter int N_OUT   = 7
) (
  input  logic [N_CHAIN-1:0] word,
  output logic [N_OUT-1:0]   idx,
  output logic               all_ones
);

  always_comb begin
    idx      = N_OUT'(N_CHAIN);
    all_ones = &word;
    for (int i = N_CHAIN - 1; i >= 0; i--) begin
      if (!word[i]) idx = N_OUT'(i);
    end
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// Three-stage thermometer-to-binary decoder with offset calibration FSM.
// Define TDC_BUBBLE_CORR_EN to enable the stage-2 majority bubble filter.
module tdc_therm_decoder
  import tdc_pkg::*;
#(
  parameter int N_CHAIN  = DEF_N_CHAIN,
  parameter int N_OUT    = $clog2(N_CHAIN) + 1,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  tdc_therm_decoder_if.slave bus
);

  localparam int ACC_W       = acc_width(N_OUT, CAL_LOG2);
  localparam int CNT_W       = CAL_LOG2 + 1;
  localparam int CAL_SAMPLES = 1 << CAL_LOG2;

  logic [N_CHAIN-1:0] s1_word_reg, s2_word_reg, s2_word_next;
  logic               s1_valid_reg, s2_valid_reg;
  logic [N_OUT-1:0]   out_code_reg, out_code_next;
  logic               out_valid_reg, out_ovf_reg;
  logic [N_OUT-1:0]   raw;
  logic               raw_ovf;

  tdc_cal_state_t     state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_OUT-1:0]   offset_reg, offset_next;
  logic               cal_busy, cal_done;

  genvar gi;

`ifdef TDC_BUBBLE_CORR_EN
  // Pad with a 1 below tap 0 and a 0 above the last tap.
  logic [N_CHAIN+1:0] ext;
  assign ext = {1'b0, s1_word_reg, 1'b1};
  for (gi = 0; gi < N_CHAIN; gi++) begin : g_maj
    assign s2_word_next[gi] = (ext[gi] & ext[gi+1]) | (ext[gi+1] & ext[gi+2]) |
                              (ext[gi] & ext[gi+2]);
  end
`else
  assign s2_word_next = s1_word_reg;
`endif

  therm_first_zero_enc #(.N_CHAIN(N_CHAIN), .N_OUT(N_OUT)) u_enc (
    .word     (s2_word_reg),
    .idx      (raw),
    .all_ones (raw_ovf)
  );

  assign out_code_next = (raw >= offset_reg) ? (raw - offset_reg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_word_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s2_word_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      out_code_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      // Alternate phase_reverse cycles capture an inverted word; tap 0 reveals which.
      s1_word_reg   <= bus.therm_in[0] ? bus.therm_in : ~bus.therm_in;
      s1_valid_reg  <= bus.in_valid;
      s2_word_reg   <= s2_word_next;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_code_reg <= out_code_next;
        out_ovf_reg  <= raw_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      offset_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      offset_reg <= offset_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    offset_next = offset_reg;
    cal_busy    = 1'b0;
    cal_done    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.cal_start) begin
          state_next = ACC;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      ACC: begin
        cal_busy = 1'b1;
        if (cnt_reg == CNT_W'(CAL_SAMPLES)) begin
          state_next = LOAD;
        end else if (s2_valid_reg) begin
          acc_next = acc_reg + ACC_W'(raw);
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        cal_done    = 1'b1;
        offset_next = N_OUT'(acc_reg >> CAL_LOG2);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_code   = out_code_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_ovf    = out_ovf_reg;
  assign bus.cal_busy   = cal_busy;
  assign bus.cal_done   = cal_done;
  assign bus.cal_offset = offset_reg;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: directed words, calibration and reset abort.
module tb_tdc_therm_decoder;

  localparam int N_CHAIN = 64;
  localparam int N_OUT   = 7;

`ifdef TDC_BUBBLE_CORR_EN
  localparam int BUB_EXP = 21;
`else
  localparam int BUB_EXP = 10;
`endif

  typedef struct {
    logic [N_OUT-1:0] code;
    logic             ovf;
    int               cyc;
    string            name;
  } exp_t;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cal_done_cnt = 0;
  exp_t sb[$];

  tdc_therm_decoder_if #(.N_CHAIN(N_CHAIN), .N_OUT(N_OUT)) bus ();

  tdc_therm_decoder #(.N_CHAIN(N_CHAIN), .N_OUT(N_OUT), .CAL_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [N_CHAIN-1:0] mk(input int c);
    logic [N_CHAIN-1:0] one;
    one = 1;
    if (c >= N_CHAIN) return '1;
    return (one << c) - 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [N_CHAIN-1:0] w, input int code, input logic ovf,
                      input string name);
    exp_t e;
    e.code = N_OUT'(code);
    e.ovf  = ovf;
    e.cyc  = cyc + 3;
    e.name = name;
    sb.push_back(e);
    bus.therm_in = w;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_cal();
    bus.cal_start = 1'b1;
    @(posedge clk);
    #1;
    bus.cal_start = 1'b0;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: code %0d ovf %0d, expected no output",
                 bus.out_code, bus.out_ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 3;
        if (bus.out_code !== e.code || bus.out_ovf !== e.ovf || cyc != e.cyc) begin
          if (bus.out_code !== e.code) errors++;
          if (bus.out_ovf !== e.ovf) errors++;
          if (cyc != e.cyc) errors++;
          $display("FAIL %s: code %0d ovf %0d cycle %0d, expected code %0d ovf %0d cycle %0d",
                   e.name, bus.out_code, bus.out_ovf, cyc, e.code, e.ovf, e.cyc);
        end else begin
          $display("ok   %s: code %0d ovf %0d cycle %0d", e.name, bus.out_code, bus.out_ovf, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.cal_done) cal_done_cnt++;
  end

  initial begin
    logic [N_CHAIN-1:0] w;
    rst           = 1'b1;
    bus.therm_in  = '0;
    bus.in_valid  = 1'b0;
    bus.cal_start = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_code", int'(bus.out_code), 0);
    chk("rst_out_ovf", int'(bus.out_ovf), 0);
    chk("rst_cal_busy", int'(bus.cal_busy), 0);
    chk("rst_cal_done", int'(bus.cal_done), 0);
    chk("rst_cal_offset", int'(bus.cal_offset), 0);

    send(mk(21), 21, 1'b0, "code21");
    idle(1);
    send(~mk(21), 21, 1'b0, "inverted21");
    w = mk(21);
    w[10] = 1'b0;
    send(w, BUB_EXP, 1'b0, "bubble10");
    send('1, 64, 1'b1, "all_ones");
    send('0, 64, 1'b1, "all_zeros");
    send(mk(1), 1, 1'b0, "code1");
    send(mk(63), 63, 1'b0, "code63");
    send(mk(32), 32, 1'b0, "code32");
    idle(5);
    chk("hold_out_valid", int'(bus.out_valid), 0);
    chk("hold_out_code", int'(bus.out_code), 32);

    // Abort a calibration with reset after seven samples.
    pulse_cal();
    for (int i = 0; i < 7; i++) send(mk(9), 9, 1'b0, "abort_sample");
    idle(5);
    chk("abort_busy_before_rst", int'(bus.cal_busy), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("abort_cal_busy", int'(bus.cal_busy), 0);
    chk("abort_cal_offset", int'(bus.cal_offset), 0);
    chk("abort_no_done", cal_done_cnt, 0);

    // Full calibration: eight 5s, an ignored restart, eight 6s -> offset 5.
    pulse_cal();
    for (int i = 0; i < 8; i++) send(mk(5), 5, 1'b0, "cal_sample5");
    pulse_cal();
    for (int i = 0; i < 8; i++) send(mk(6), 6, 1'b0, "cal_sample6");
    for (int i = 0; i < 30 && cal_done_cnt == 0; i++) idle(1);
    chk("cal_done_pulses", cal_done_cnt, 1);
    idle(2);
    chk("cal_offset", int'(bus.cal_offset), 5);
    chk("cal_busy_after", int'(bus.cal_busy), 0);

    send(mk(21), 16, 1'b0, "offs_code21");
    send(mk(3), 0, 1'b0, "offs_sat3");
    send(mk(5), 0, 1'b0, "offs_equal5");
    send(mk(6), 1, 1'b0, "offs_code6");
    send('1, 59, 1'b1, "offs_ovf");
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outstanding, expected 0", sb.size());
    end
    chk("cal_done_total", cal_done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
